// File: rtl/mm_deskew_if.sv
// Stream interface for mm_deskew: skewed row input plus aligned valid/ready output.
// The slave modport is the deskew block; the master modport is the array/consumer side.
interface mm_deskew_if #(
  parameter int D_W   = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic [LANES*D_W-1:0]     in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*D_W-1:0]     out_data;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, level, overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, level, overflow
  );
endinterface

// File: rtl/mm_deskew.sv
// Undoes the per-lane output skew of the systolic array and queues each aligned
// row in a small first-word-fall-through FIFO; overflow drops the word and sets a sticky flag.
module mm_deskew #(
  parameter int D_W   = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mm_deskew_if.slave   bus
);
  localparam int W  = LANES * D_W;
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]       aligned;
  logic [LANES-2:0]   vpipe;
  logic               push;
  logic               pop;
  logic               wr_en;
  logic               full;
  logic [W-1:0]       mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               ovf_q;

  // Lane k waits LANES-1-k cycles so every lane of a row lines up with the last lane.
  for (genvar k = 0; k < LANES - 1; k++) begin : g_lane
    localparam int N = LANES - 1 - k;
    logic [D_W-1:0] stage [N];

    always_ff @(posedge clk) begin
      stage[0] <= bus.in_data[k*D_W +: D_W];
      for (int s = 1; s < N; s++) begin
        stage[s] <= stage[s-1];
      end
    end

    assign aligned[k*D_W +: D_W] = stage[N-1];
  end

  assign aligned[(LANES-1)*D_W +: D_W] = bus.in_data[(LANES-1)*D_W +: D_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= bus.in_valid;
      for (int s = 1; s < LANES - 1; s++) begin
        vpipe[s] <= vpipe[s-1];
      end
    end
  end

  assign push  = vpipe[LANES-2];
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = (count != '0) && bus.out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= aligned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !wr_en) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid = (count != '0);
  assign bus.out_data  = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.level     = count;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mm_deskew.sv
// Directed bench for mm_deskew: drives skewed rows and compares every cycle
// against a queue of expected aligned words.
module tb_mm_deskew;
  localparam int D_W   = 8;
  localparam int LANES = 4;
  localparam int DEPTH = 4;
  localparam int W     = LANES * D_W;

  logic clk = 1'b0;
  logic rst_n;

  mm_deskew_if #(.D_W(D_W), .LANES(LANES), .DEPTH(DEPTH)) bus ();

  mm_deskew #(.D_W(D_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            max_level;
  logic [W-1:0]  sb [$];
  logic          model_ovf;
  logic [W-1:0]  hist_d [LANES];
  logic          hist_v [LANES];

  function automatic logic [W-1:0] mk_row(input int r);
    return {8'(r + 3), 8'(r + 2), 8'(r + 1), 8'(r)};
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag);
    logic [W-1:0] exp_data;
    exp_data = (sb.size() != 0) ? sb[0] : '0;
    checkOutput({tag, ".out_valid"}, W'(bus.out_valid), W'(sb.size() != 0));
    checkOutput({tag, ".level"},     W'(bus.level),     W'(sb.size()));
    checkOutput({tag, ".out_data"},  bus.out_data,      exp_data);
    checkOutput({tag, ".overflow"},  W'(bus.overflow),  W'(model_ovf));
  endtask

  // One clock cycle: present lane k of the row started k cycles ago, check, then advance the model.
  task automatic applyStimulus(input logic v, input logic [W-1:0] row, input logic rdy);
    for (int k = LANES - 1; k > 0; k--) begin
      hist_d[k] = hist_d[k-1];
      hist_v[k] = hist_v[k-1];
    end
    hist_d[0] = row;
    hist_v[0] = v;
    for (int k = 0; k < LANES; k++) begin
      bus.in_data[k*D_W +: D_W] = hist_v[k] ? hist_d[k][k*D_W +: D_W] : D_W'($urandom);
    end
    bus.in_valid  = v;
    bus.out_ready = rdy;
    #1;
    checkState("cycle");
    if (int'(bus.level) > max_level) max_level = int'(bus.level);
    if (sb.size() != 0 && rdy) void'(sb.pop_front());
    if (hist_v[LANES-1]) begin
      if (sb.size() < DEPTH) sb.push_back(hist_d[LANES-1]);
      else model_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    sb.delete();
    model_ovf = 1'b0;
    for (int k = 0; k < LANES; k++) hist_v[k] = 1'b0;
    checkState("reset");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, rdy);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_ovf     = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      hist_v[k] = 1'b0;
      hist_d[k] = '0;
    end
    #2;
    applyReset();

    // Single row, held at the head until one ready pulse.
    applyStimulus(1'b1, 32'h44332211, 1'b0);
    idle(3, 1'b0);
    checkOutput("single.valid", W'(bus.out_valid), W'(1));
    checkOutput("single.data",  bus.out_data,      32'h44332211);
    checkOutput("single.level", W'(bus.level),     W'(1));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("single.drained_level", W'(bus.level), W'(0));
    checkOutput("single.drained_data",  bus.out_data,  W'(0));
    idle(2, 1'b0);

    // Streaming with the consumer always ready.
    max_level = 0;
    for (int r = 0; r < 8; r++) applyStimulus(1'b1, mk_row(r), 1'b1);
    idle(5, 1'b1);
    checkOutput("stream.max_level", W'(max_level > 1), W'(0));
    checkOutput("stream.overflow",  W'(bus.overflow),  W'(0));

    // Overflow: five rows into a stalled four-deep FIFO.
    for (int r = 16; r < 21; r++) applyStimulus(1'b1, mk_row(r), 1'b0);
    idle(4, 1'b0);
    checkOutput("ovf.level",    W'(bus.level),    W'(4));
    checkOutput("ovf.overflow", W'(bus.overflow), W'(1));
    checkOutput("ovf.head",     bus.out_data,     mk_row(16));
    idle(5, 1'b1);
    checkOutput("ovf.drained_level", W'(bus.level),    W'(0));
    checkOutput("ovf.sticky",        W'(bus.overflow), W'(1));

    // Full FIFO with a pop landing exactly on the push edge of the fifth row.
    applyReset();
    for (int r = 32; r < 37; r++) applyStimulus(1'b1, mk_row(r), 1'b0);
    idle(2, 1'b0);
    checkOutput("fullpop.level_before", W'(bus.level), W'(4));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("fullpop.level",    W'(bus.level),    W'(4));
    checkOutput("fullpop.overflow", W'(bus.overflow), W'(0));
    checkOutput("fullpop.head",     bus.out_data,     mk_row(33));
    idle(5, 1'b1);
    checkOutput("fullpop.drained", W'(bus.level), W'(0));

    // Reset in the middle of a row with two words queued.
    applyStimulus(1'b1, mk_row(48), 1'b0);
    applyStimulus(1'b1, mk_row(52), 1'b0);
    idle(3, 1'b0);
    checkOutput("midrst.level_before", W'(bus.level), W'(2));
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyReset();
    checkOutput("midrst.out_valid", W'(bus.out_valid), W'(0));
    checkOutput("midrst.out_data",  bus.out_data,      W'(0));
    checkOutput("midrst.level",     W'(bus.level),     W'(0));
    checkOutput("midrst.overflow",  W'(bus.overflow),  W'(0));
    idle(5, 1'b1);
    applyStimulus(1'b1, 32'hA5C3E187, 1'b0);
    idle(2, 1'b0);
    checkOutput("midrst.not_yet", W'(bus.out_valid), W'(0));
    idle(1, 1'b0);
    checkOutput("midrst.new_valid", W'(bus.out_valid), W'(1));
    checkOutput("midrst.new_data",  bus.out_data,      32'hA5C3E187);
    applyStimulus(1'b0, '0, 1'b1);
    idle(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mm_deskew.md
# mm_deskew

Output-side realignment stage for the systolic matrix-multiply array. The array's result columns leave skewed by one cycle per lane, mirroring the input-side delay lines. This block undoes that skew and reassembles each result row into one aligned word. Aligned rows are buffered in a small first-word-fall-through FIFO and presented to the downstream consumer with a valid/ready handshake. The array cannot be stalled, so FIFO overflow drops the word and raises a sticky flag.

## Interface
- D_W, 8, bits per result element (lane)
- LANES, 4, number of skewed lanes (array columns); ≥2
- DEPTH, 4, FIFO depth in aligned words; power of 2, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  qualifies lane 0 of a new row in this cycle
- in_data  in  LANES*D_W  lane k at in_data[k*D_W +: D_W]
- out_valid  out  1  aligned word available at FIFO head
- out_ready  in  1  consumer accepts head word when out_valid=1
- out_data  out  LANES*D_W  aligned row; lane k at out_data[k*D_W +: D_W]
- level  out  $clog2(DEPTH)+1  number of words currently in FIFO
- overflow  out  1  sticky; set when an aligned word is dropped

## Operation
- Skew model: a row whose lane 0 is sampled at edge t (in_valid=1) has lane k sampled at edge t+k. Lanes k>0 carry no valid of their own; they are captured unconditionally and qualified by the internally delayed in_valid.
- Deskew: lane k passes through LANES-1-k register stages. Lane LANES-1 is used directly from the input. in_valid passes through LANES-1 stages to form push.
- Push occurs at edge t+LANES-1. The aligned word is {lane LANES-1 @t+LANES-1, …, lane 1 @t+1, lane 0 @t}.
- Rows may arrive on consecutive cycles; partial rows overlap in the skew registers without interference.
- FIFO behaviour:
  - Circular buffer with read/write pointers and occupancy count.
  - out_valid = (level != 0).
  - out_data = head word when out_valid=1, else all zeros.
  - Pop = out_valid && out_ready.
- Push when level=DEPTH and no pop in the same cycle: the word is discarded, overflow is set, and level is unchanged.
- Push and pop in the same cycle while full: both occur, nothing is dropped, level stays DEPTH.
- Push while empty: no bypass. The word becomes visible the cycle after the write edge. A pop in that same cycle is impossible because out_valid=0.
- overflow clears only on reset.
- Reset (rst_n low, any time):
  - Clears skew-stage valids, pointers, level and overflow.
  - Partially collected rows are discarded and produce no output after release.
  - Data registers need not be cleared.
  - Outputs during and after reset: out_valid=0, out_data=0, level=0, overflow=0.

## Timing
- Latency: in_valid at edge t gives out_valid=1 in the cycle after edge t+LANES-1 (FIFO empty before). That is LANES-1 cycles from lane-0 capture to write, with out_valid visible one cycle later.
- Throughput: one aligned word per cycle sustained when out_ready=1.
- level updates at the same edge as push/pop: +1 for push only, −1 for pop only, unchanged for both or neither or a dropped push.
- out_data/out_valid are registered-state derived. out_ready has no combinational path to anything except pop.
- overflow rises in the cycle after the dropping edge.

## Test plan
All scenarios use D_W=8, LANES=4, DEPTH=4.
- Single row:
  - Stimulus: in_valid=1 at edge 0 with lane0=0x11; lane1=0x22 @edge1, lane2=0x33 @edge2, lane3=0x44 @edge3; out_ready=0.
  - Required: out_valid rises after edge 3, out_data=0x44332211, level=1. One out_ready pulse returns level to 0 and out_data to 0.
- Streaming:
  - Stimulus: 8 consecutive rows, row r lanes = {r,r,r,r}+lane index, out_ready=1.
  - Required: 8 words in order, one per cycle. level never exceeds 1, overflow stays 0.
- Overflow:
  - Stimulus: out_ready=0, 5 back-to-back rows.
  - Required: level reaches 4. Row 5 is dropped, overflow=1. Draining yields rows 1–4 in order, level returns to 0, overflow remains 1.
- Full with simultaneous pop:
  - Stimulus: level=4, out_ready=1 in the exact cycle the next aligned word is pushed.
  - Required: no drop, level stays 4, overflow=0, new row appears last in order.
- Reset mid-row:
  - Stimulus: drop rst_n after lanes 0–1 of a row are captured, with 2 words already in the FIFO.
  - Required: level, out_valid, out_data and overflow are 0 immediately. No word from the interrupted row ever appears. The next full row after release outputs correctly with latency 3+1.
